reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//   Parametrised multi-port general-purpose register file for the datapath.
//   Two async read ports, one sync write port, optional hardwired zero register.
//   Hardware clear sequencer zeroes every entry after reset or on request.
//   Sits between decode (read addresses) and writeback (write port).
// PARAMETERS
//   DATA_W    64  bits per register
//   DEPTH     32  number of registers; ADDR_W = $clog2(DEPTH) (localparam)
//   HAS_ZERO  1   1: register ZERO_REG always reads 0, writes to it ignored
//   ZERO_REG  31  index of the hardwired zero register (used only if HAS_ZERO=1)
// PORTS
//   CLK                in   1       system clock, rising edge
//   RESET_N            in   1       asynchronous active-low reset
//   CLEAR_REQ          in   1       pulse: restart clear sweep (sampled when READY=1)
//   READ_REG_A         in   ADDR_W  read address, port A
//   READ_REG_B         in   ADDR_W  read address, port B
//   WRITE_REG          in   ADDR_W  write address
//   WRITE_DATA         in   DATA_W  write data
//   REG_WRITE_ENABLE   in   1       write strobe, sampled on rising CLK
//   DATA_OUT_A         out  DATA_W  read data, port A (combinational)
//   DATA_OUT_B         out  DATA_W  read data, port B (combinational)
//   READY              out  1       1 = clear done, reads/writes valid
// BEHAVIOUR
//   - Reset (RESET_N=0, async): FSM -> CLEAR, sweep index -> 0, READY -> 0.
//     Array contents not reset directly; cleared by the sweep.
//   - FSM CLEAR: each rising CLK writes 0 to entry[index], index++.
//     After entry DEPTH-1 is written -> RUN; READY=1 on the following cycle,
//     i.e. READY rises DEPTH cycles after RESET_N deasserts.
//   - FSM RUN: REG_WRITE_ENABLE=1 writes WRITE_DATA to WRITE_REG at rising CLK.
//     CLEAR_REQ=1 at a rising edge -> CLEAR, index=0, READY=0 next cycle;
//     a write in that same cycle is still performed (then swept to 0).
//   - While READY=0: writes ignored; DATA_OUT_A/B forced to 0.
//   - Reads: DATA_OUT_x = entry[READ_REG_x], zero latency. A==B allowed.
//   - HAS_ZERO=1: read of ZERO_REG returns 0; write to ZERO_REG discarded.
//   - WRITE_REG/READ_REG >= DEPTH (non-power-of-2 DEPTH): write discarded,
//     read returns 0.
//   - Reset asserted mid-sweep: sweep restarts from index 0.
//   - CLEAR_REQ while READY=0: ignored (sweep already in progress).
//   - No X on outputs after reset in any state.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: write-to-read forwarding. If READY=1,
//     REG_WRITE_ENABLE=1, WRITE_REG==READ_REG_x and WRITE_REG is writable,
//     DATA_OUT_x = WRITE_DATA in the same cycle (before the edge).
//   Not defined: DATA_OUT_x shows old contents until after the write edge.
//   Zero register and out-of-range rules take priority over bypass.
// TESTING
//   1. Release RESET_N, DEPTH=32 -> READY=0 for 32 cycles, 1 at cycle 32;
//      every register then reads 0.
//   2. READY=1, write R5=64'hDEAD_BEEF_0000_0001 -> next cycle
//      READ_REG_A=5 and READ_REG_B=5 both return that value.
//   3. Write R31=64'hFFFF (HAS_ZERO=1) -> R31 reads 0; HAS_ZERO=0 reads 64'hFFFF.
//   4. Write R3=64'h000A and read A=3 same cycle -> 64'h000A with
//      REGFILE_BYPASS_EN, previous value (0) without; 64'h000A after edge in both.
//   5. R1=64'h5, pulse CLEAR_REQ -> READY=0 for 32 cycles, writes during sweep
//      ignored, R1 reads 0 afterwards.
//   6. Assert RESET_N=0 at sweep index 10 -> READY stays 0; after release
//      full 32-cycle sweep repeats before READY=1.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// optional hardwired zero register, hardware clear sweep. Optional forwarding: REGFILE_BYPASS_EN.
//
// state    | meaning
// ST_CLEAR | sweeping zeros into entry[idx_q]; READY=0, reads return 0, writes ignored
// ST_RUN   | normal operation; READY=1
module reg_file_param #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 32,
    parameter int HAS_ZERO = 1,
    parameter int ZERO_REG = 31,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CLEAR_REQ,
    input  logic [ADDR_W-1:0] READ_REG_A,
    input  logic [ADDR_W-1:0] READ_REG_B,
    input  logic [ADDR_W-1:0] WRITE_REG,
    input  logic [DATA_W-1:0] WRITE_DATA,
    input  logic              REG_WRITE_ENABLE,
    output logic [DATA_W-1:0] DATA_OUT_A,
    output logic [DATA_W-1:0] DATA_OUT_B,
    output logic              READY
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(ZERO_REG);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;

    // An address is live when it maps to a real entry that is not the hardwired zero.
    function automatic logic addr_live(input logic [ADDR_W-1:0] addr);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, addr} < DEPTH_EXT);
        is_zero  = (HAS_ZERO != 0) && (addr == ZERO_IDX);
        return in_range && !is_zero;
    endfunction

    assign READY = (state_q == ST_RUN);
    assign wr_en = READY && REG_WRITE_ENABLE && addr_live(WRITE_REG);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (CLEAR_REQ) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // Storage has no reset; the sweep is what initialises it.
    always_ff @(posedge CLK) begin
        if (state_q == ST_CLEAR) begin
            mem[idx_q] <= '0;
        end else if (wr_en) begin
            mem[WRITE_REG] <= WRITE_DATA;
        end
    end

    always_comb begin
        DATA_OUT_A = '0;
        if (READY && addr_live(READ_REG_A)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (WRITE_REG == READ_REG_A)) begin
                DATA_OUT_A = WRITE_DATA;
            end else begin
                DATA_OUT_A = mem[READ_REG_A];
            end
`else
            DATA_OUT_A = mem[READ_REG_A];
`endif
        end
    end

    always_comb begin
        DATA_OUT_B = '0;
        if (READY && addr_live(READ_REG_B)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (WRITE_REG == READ_REG_B)) begin
                DATA_OUT_B = WRITE_DATA;
            end else begin
                DATA_OUT_B = mem[READ_REG_B];
            end
`else
            DATA_OUT_B = mem[READ_REG_B];
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: one instance with a hardwired zero register, one without,
// both driven by the same stimulus and checked against an array-based reference model.
module tb_reg_file_param;

    localparam int DW = 64;
    localparam int DP = 32;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          CLEAR_REQ;
    logic [AW-1:0] READ_REG_A, READ_REG_B, WRITE_REG;
    logic [DW-1:0] WRITE_DATA;
    logic          REG_WRITE_ENABLE;

    logic [DW-1:0] out_a [2];
    logic [DW-1:0] out_b [2];
    logic          rdy   [2];

    int checks = 0;
    int errors = 0;

    // Reference model: contents per instance, ready flag, sweep cycle count.
    logic [DW-1:0] m_mem [2][DP];
    bit            m_ready;
    int            m_cnt;

    always #5 CLK = ~CLK;

    reg_file_param #(.DATA_W(DW), .DEPTH(DP), .HAS_ZERO(1), .ZERO_REG(31)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CLEAR_REQ(CLEAR_REQ),
        .READ_REG_A(READ_REG_A), .READ_REG_B(READ_REG_B),
        .WRITE_REG(WRITE_REG), .WRITE_DATA(WRITE_DATA),
        .REG_WRITE_ENABLE(REG_WRITE_ENABLE),
        .DATA_OUT_A(out_a[0]), .DATA_OUT_B(out_b[0]), .READY(rdy[0])
    );

    reg_file_param #(.DATA_W(DW), .DEPTH(DP), .HAS_ZERO(0), .ZERO_REG(31)) dut_nz (
        .CLK(CLK), .RESET_N(RESET_N), .CLEAR_REQ(CLEAR_REQ),
        .READ_REG_A(READ_REG_A), .READ_REG_B(READ_REG_B),
        .WRITE_REG(WRITE_REG), .WRITE_DATA(WRITE_DATA),
        .REG_WRITE_ENABLE(REG_WRITE_ENABLE),
        .DATA_OUT_A(out_a[1]), .DATA_OUT_B(out_b[1]), .READY(rdy[1])
    );

    function automatic bit writable(int inst, logic [AW-1:0] addr);
        return !(inst == 0 && addr == 5'd31);
    endfunction

    function automatic logic [DW-1:0] exp_rd(int inst, logic [AW-1:0] addr);
        if (!m_ready) return '0;
        if (!writable(inst, addr)) return '0;
`ifdef REGFILE_BYPASS_EN
        if (REG_WRITE_ENABLE && WRITE_REG == addr) return WRITE_DATA;
`endif
        return m_mem[inst][addr];
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        if (!RESET_N) begin
            model_reset();
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DP) begin
                m_ready = 1'b1;
                for (int i = 0; i < 2; i++)
                    for (int r = 0; r < DP; r++) m_mem[i][r] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++)
                if (REG_WRITE_ENABLE && writable(i, WRITE_REG)) m_mem[i][WRITE_REG] = WRITE_DATA;
            if (CLEAR_REQ) model_reset();
        end
    endtask

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready[%0d]", i), {63'd0, rdy[i]}, {63'd0, m_ready});
            chk($sformatf("rd_a[%0d] r%0d", i, READ_REG_A), out_a[i], exp_rd(i, READ_REG_A));
            chk($sformatf("rd_b[%0d] r%0d", i, READ_REG_B), out_b[i], exp_rd(i, READ_REG_B));
        end
    endtask

    // Inputs change only on the falling edge; outputs are checked just after.
    task automatic cycle();
        check_outputs();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic idle();
        CLEAR_REQ        = 1'b0;
        REG_WRITE_ENABLE = 1'b0;
    endtask

    task automatic write(logic [AW-1:0] a, logic [DW-1:0] d);
        REG_WRITE_ENABLE = 1'b1;
        WRITE_REG        = a;
        WRITE_DATA       = d;
        cycle();
        REG_WRITE_ENABLE = 1'b0;
    endtask

    task automatic sweep_and_check_ready(string tag);
        for (int c = 0; c < DP; c++) begin
            chk({tag, " ready low"}, {63'd0, rdy[0]}, 64'd0);
            REG_WRITE_ENABLE = 1'b1;
            WRITE_REG        = AW'($urandom_range(0, DP - 1));
            WRITE_DATA       = {$urandom, $urandom};
            CLEAR_REQ        = 1'($urandom_range(0, 1));
            cycle();
        end
        idle();
        #1;
        chk({tag, " ready high"}, {63'd0, rdy[0]}, 64'd1);
    endtask

    initial begin
        RESET_N = 1'b0;
        idle();
        READ_REG_A = '0; READ_REG_B = '0; WRITE_REG = '0; WRITE_DATA = '0;
        model_reset();
        repeat (3) cycle();
        RESET_N = 1'b1;

        // Release: 32-cycle sweep, then every register reads 0
        sweep_and_check_ready("init");
        for (int r = 0; r < DP; r++) begin
            READ_REG_A = AW'(r);
            READ_REG_B = AW'(DP - 1 - r);
            cycle();
        end

        // R5 write, both ports read it on the next cycle
        write(5'd5, 64'hDEAD_BEEF_0000_0001);
        READ_REG_A = 5'd5; READ_REG_B = 5'd5;
        #1;
        chk("r5 port a", out_a[0], 64'hDEAD_BEEF_0000_0001);
        chk("r5 port b", out_b[0], 64'hDEAD_BEEF_0000_0001);
        cycle();

        // Zero register: hardwired instance reads 0, plain instance keeps the data
        write(5'd31, 64'hFFFF);
        READ_REG_A = 5'd31;
        #1;
        chk("r31 zero", out_a[0], 64'h0);
        chk("r31 plain", out_a[1], 64'hFFFF);
        cycle();

        // Same-cycle write and read of R3
        READ_REG_A = 5'd3;
        REG_WRITE_ENABLE = 1'b1; WRITE_REG = 5'd3; WRITE_DATA = 64'h000A;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("r3 same cycle", out_a[0], 64'h000A);
`else
        chk("r3 same cycle", out_a[0], 64'h0);
`endif
        cycle();
        idle();
        #1;
        chk("r3 after edge", out_a[0], 64'h000A);
        cycle();

        // Clear request: sweep, writes ignored, R1 zero afterwards
        write(5'd1, 64'h5);
        READ_REG_A = 5'd1;
        #1;
        chk("r1 before clear", out_a[0], 64'h5);
        CLEAR_REQ = 1'b1;
        cycle();
        sweep_and_check_ready("clear");
        READ_REG_A = 5'd1;
        #1;
        chk("r1 after clear", out_a[0], 64'h0);
        cycle();

        // Reset at sweep index 10 restarts the full sweep
        CLEAR_REQ = 1'b1;
        cycle();
        idle();
        repeat (10) cycle();
        RESET_N = 1'b0;
        model_reset();
        repeat (2) cycle();
        RESET_N = 1'b1;
        sweep_and_check_ready("midreset");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            READ_REG_A       = AW'($urandom_range(0, DP - 1));
            READ_REG_B       = ($urandom_range(0, 3) == 0) ? READ_REG_A : AW'($urandom_range(0, DP - 1));
            REG_WRITE_ENABLE = 1'($urandom_range(0, 1));
            WRITE_REG        = ($urandom_range(0, 3) == 0) ? READ_REG_A : AW'($urandom_range(0, DP - 1));
            WRITE_DATA       = {$urandom, $urandom};
            CLEAR_REQ        = ($urandom_range(0, 99) == 0);
            cycle();
        end
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
